// File: rtl/amm_dp_ram_if.sv
// -----------------------------------------------------------------------------
// amm_dp_ram_if
// Avalon-MM bundle for the dual-port RAM: a read-only channel (amm_rd_*)
// and a write-only channel (amm_wr_*).
//   master modport : drives address/request/data/byteenable, sees waitrequest
//                    and read return data
//   slave  modport : the RAM side of the same signals
// -----------------------------------------------------------------------------
interface amm_dp_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_CNT   = DATA_WIDTH / 8
);
    // read channel
    logic [ADDR_WIDTH-1:0] amm_rd_address_i;
    logic                  amm_rd_read_i;
    logic                  amm_rd_waitrequest_o;
    logic [DATA_WIDTH-1:0] amm_rd_readdata_o;
    logic                  amm_rd_readdatavalid_o;
    // write channel
    logic [ADDR_WIDTH-1:0] amm_wr_address_i;
    logic                  amm_wr_write_i;
    logic [DATA_WIDTH-1:0] amm_wr_writedata_i;
    logic [BYTE_CNT-1:0]   amm_wr_byteenable_i;
    logic                  amm_wr_waitrequest_o;

    modport master (
        output amm_rd_address_i, amm_rd_read_i,
        input  amm_rd_waitrequest_o, amm_rd_readdata_o, amm_rd_readdatavalid_o,
        output amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
        input  amm_wr_waitrequest_o
    );

    modport slave (
        input  amm_rd_address_i, amm_rd_read_i,
        output amm_rd_waitrequest_o, amm_rd_readdata_o, amm_rd_readdatavalid_o,
        input  amm_wr_address_i, amm_wr_write_i, amm_wr_writedata_i, amm_wr_byteenable_i,
        output amm_wr_waitrequest_o
    );
endinterface

// File: rtl/amm_dp_ram.sv
// -----------------------------------------------------------------------------
// amm_dp_ram
// Word-addressed dual-port Avalon-MM memory slave. One read-only port, one
// write-only port with byte-enable masking, fixed read latency and a
// deterministic number of waitrequest cycles before each acceptance.
//
// Ports:
//   clk_i  : clock
//   srst_i : asynchronous active-high reset (memory contents are kept)
//   bus    : amm_dp_ram_if.slave - read channel (address/read/waitrequest/
//            readdata/readdatavalid) and write channel (address/write/
//            writedata/byteenable/waitrequest)
// -----------------------------------------------------------------------------
module amm_dp_ram #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int BYTE_CNT        = DATA_WIDTH / 8,
    parameter int READ_LATENCY    = 2,
    parameter int RD_STALL_CYCLES = 0,
    parameter int WR_STALL_CYCLES = 0
) (
    input  logic         clk_i,
    input  logic         srst_i,
    amm_dp_ram_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // counters need at least one bit even when no stall is configured
    localparam int RD_CW = (RD_STALL_CYCLES > 0) ? $clog2(RD_STALL_CYCLES + 1) : 1;
    localparam int WR_CW = (WR_STALL_CYCLES > 0) ? $clog2(WR_STALL_CYCLES + 1) : 1;
    localparam logic [RD_CW-1:0] RD_STALL_MAX = RD_CW'(RD_STALL_CYCLES);
    localparam logic [WR_CW-1:0] WR_STALL_MAX = WR_CW'(WR_STALL_CYCLES);

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [RD_CW-1:0]        rd_cnt_r;
    logic [WR_CW-1:0]        wr_cnt_r;
    logic                    rd_wait_s;
    logic                    rd_acc_s;
    logic                    wr_wait_s;
    logic                    wr_acc_s;
    // stage 0 is loaded on acceptance, stage READ_LATENCY-1 drives the port
    logic [READ_LATENCY-1:0] vld_r;
    logic [DATA_WIDTH-1:0]   dat_r [READ_LATENCY];

    // Waitrequest is combinational from the request so a request is held off
    // for exactly STALL_CYCLES cycles, then accepted.
    assign rd_wait_s = bus.amm_rd_read_i && (rd_cnt_r != RD_STALL_MAX);
    assign rd_acc_s  = bus.amm_rd_read_i && !rd_wait_s;
    assign wr_wait_s = bus.amm_wr_write_i && (wr_cnt_r != WR_STALL_MAX);
    assign wr_acc_s  = bus.amm_wr_write_i && !wr_wait_s;

    assign bus.amm_rd_waitrequest_o   = rd_wait_s;
    assign bus.amm_wr_waitrequest_o   = wr_wait_s;
    assign bus.amm_rd_readdatavalid_o = vld_r[READ_LATENCY-1];
    assign bus.amm_rd_readdata_o      = dat_r[READ_LATENCY-1];

    // Read stall counter: counts stalled cycles, clears on acceptance, holds while idle.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            rd_cnt_r <= '0;
        end else if (rd_wait_s) begin
            rd_cnt_r <= rd_cnt_r + RD_CW'(1);
        end else if (rd_acc_s) begin
            rd_cnt_r <= '0;
        end else begin
            rd_cnt_r <= rd_cnt_r;
        end
    end

    // Write stall counter: same scheme as the read side.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            wr_cnt_r <= '0;
        end else if (wr_wait_s) begin
            wr_cnt_r <= wr_cnt_r + WR_CW'(1);
        end else if (wr_acc_s) begin
            wr_cnt_r <= '0;
        end else begin
            wr_cnt_r <= wr_cnt_r;
        end
    end

    // Memory array write with byte lanes; deliberately not reset so contents survive srst_i.
    always_ff @(posedge clk_i) begin
        if (wr_acc_s) begin
            for (int b = 0; b < BYTE_CNT; b++) begin
                if (bus.amm_wr_byteenable_i[b]) begin
                    mem_r[bus.amm_wr_address_i][8*b +: 8] <= bus.amm_wr_writedata_i[8*b +: 8];
                end
            end
        end
    end

    // Read latency pipeline. Stage 0 samples the array with the pre-write value
    // (read-first on same-address collision). Data stages only load on a valid
    // input, so the output stage holds the last returned word between strobes.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            vld_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                dat_r[0] <= mem_r[bus.amm_rd_address_i];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

endmodule

// File: doc/amm_dp_ram.md
Name: amm_dp_ram

Overview:
- Word-addressed dual-port Avalon-MM memory slave: one read-only port and one write-only port.
- Sits directly downstream of the byte increment engine. Its read port serves the engine's amm_rd master; its write port accepts the engine's amm_wr master, with byte-enable masking.
- Provides a fixed, parameterised read latency and deterministic waitrequest back-pressure. System-level simulation and FPGA builds use it as the real backing store instead of a behavioural model.

Parameters:
- DATA_WIDTH, 64: word width in bits; multiple of 8.
- ADDR_WIDTH, 10: word address width; depth = 2**ADDR_WIDTH words.
- BYTE_CNT, DATA_WIDTH/8: byteenable width.
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid; legal range 1..8.
- RD_STALL_CYCLES, 0: waitrequest cycles inserted before each read is accepted.
- WR_STALL_CYCLES, 0: waitrequest cycles inserted before each write is accepted.

Ports:
- clk_i  in  1  clock
- srst_i  in  1  reset, asynchronous, active-high
- amm_rd_address_i  in  ADDR_WIDTH  read word address
- amm_rd_read_i  in  1  read request
- amm_rd_waitrequest_o  out  1  read not accepted this cycle
- amm_rd_readdata_o  out  DATA_WIDTH  read data
- amm_rd_readdatavalid_o  out  1  readdata valid strobe
- amm_wr_address_i  in  ADDR_WIDTH  write word address
- amm_wr_write_i  in  1  write request
- amm_wr_writedata_i  in  DATA_WIDTH  write data
- amm_wr_byteenable_i  in  BYTE_CNT  byte lane enables; bit i covers data[8i+7:8i]
- amm_wr_waitrequest_o  out  1  write not accepted this cycle

Behaviour:
- Reset state (asynchronous, while srst_i=1):
  - readdatavalid_o=0 and readdata_o=0.
  - All latency-pipeline valid bits cleared.
  - Stall counters cleared to 0.
  - Memory array is not reset; contents are preserved across reset.
- Waitrequest (per port, counter 0..STALL_CYCLES):
  - waitrequest_o = request_i && (cnt != STALL_CYCLES). This is combinational from the request input.
  - Each cycle that request_i=1 and waitrequest_o=1, cnt increments.
  - Acceptance: request_i=1 and waitrequest_o=0 at the posedge. On acceptance cnt returns to 0.
  - request_i=0 leaves cnt unchanged.
  - With STALL_CYCLES=0, every request is accepted in the cycle it is presented.
- Master obligation: address, data and byteenable are held stable while waitrequest_o=1. The slave samples them only on acceptance.
- Write: on acceptance, only bytes with byteenable=1 are written; other bytes keep their old value. byteenable=0 completes the handshake with no change to memory.
- Read pipeline:
  - An accepted read at posedge k drives readdatavalid_o=1 with the addressed word during the cycle after posedge k+READ_LATENCY-1.
  - readdatavalid_o is high for exactly one cycle per accepted read.
  - Back-to-back accepted reads give back-to-back valids, in order.
  - Outstanding reads are bounded only by READ_LATENCY; there is no internal queue limit.
- readdata_o holds its last value when readdatavalid_o=0.
- Read/write collision at the same address, both accepted at the same posedge: the read returns pre-write data (read-first).
- A write accepted at posedge k is visible to a read accepted at posedge k+1 or later.
- Read and write to different addresses in the same cycle proceed independently.
- Reset asserted mid-operation: in-flight reads are dropped and produce no readdatavalid. A stalled request restarts its stall count after reset.
- Addresses wrap naturally across the full 2**ADDR_WIDTH space; no out-of-range handling.

Test Plan:
- Write addr 5 = 64'h0807060504030201, byteenable 8'hFF. Then read addr 5 with READ_LATENCY=2 -> readdatavalid high exactly 2 cycles after acceptance; readdata 64'h0807060504030201.
- Addr 5 holds 64'h0807060504030201. Write addr 5 = 64'hFFFF_FFFF_FFFF_FFFF with byteenable 8'h0F -> a subsequent read returns 64'h08070605FFFFFFFF.
- RD_STALL_CYCLES=3, read held high -> waitrequest high for 3 cycles, acceptance on the 4th cycle, one readdatavalid. WR_STALL_CYCLES=2 -> write is committed on the 3rd cycle only.
- Reads to addrs 0,1,2,3 on consecutive cycles with no stall -> four consecutive readdatavalid cycles returning words 0..3 in order.
- Addr 7 holds 64'h11. In the same cycle, read addr 7 and write addr 7 = 64'h22 -> the read returns 64'h11. A read in the next cycle returns 64'h22.
- Assert srst_i asynchronously 1 cycle after two reads are accepted -> readdatavalid stays 0 and readdata goes to 0 immediately. After release, reading back previously written words returns the preserved contents.
